// File: rtl/imem_fetch.sv
// imem_fetch: instruction fetch unit. Owns the program counter, issues reads
// to a one-cycle-latency synchronous instruction memory, buffers the returned
// words with their addresses in a small FIFO and presents the FIFO head to
// decode with a valid/ready handshake. A redirect flushes everything and
// restarts fetch at a new word-aligned address.

package pkg_parameters;
    parameter int IMEM_ADDR_WIDTH = 32;
    parameter int IMEM_DATA_WIDTH = 32;
endpackage

module imem_fetch #(
    parameter int IMEM_ADDR_WIDTH = pkg_parameters::IMEM_ADDR_WIDTH,
    parameter int IMEM_DATA_WIDTH = pkg_parameters::IMEM_DATA_WIDTH,
    parameter logic [IMEM_ADDR_WIDTH-1:0] RESET_PC = '0,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       imem_ena,
    output logic [IMEM_ADDR_WIDTH-1:0] imem_addr,
    input  logic [IMEM_DATA_WIDTH-1:0] imem_dout,
    input  logic                       redirect_valid,
    input  logic [IMEM_ADDR_WIDTH-1:0] redirect_pc,
    output logic                       inst_valid,
    input  logic                       inst_ready,
    output logic [IMEM_DATA_WIDTH-1:0] inst_data,
    output logic [IMEM_ADDR_WIDTH-1:0] inst_pc
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    // Occupancy math carries one spare bit so count + inflight never wraps.
    localparam int OCC_W = $clog2(FIFO_DEPTH) + 2;
    localparam logic [IMEM_ADDR_WIDTH-1:0] PC_STEP    = IMEM_ADDR_WIDTH'(IMEM_DATA_WIDTH / 8);
    localparam logic [IMEM_ADDR_WIDTH-1:0] ALIGN_MASK = ~IMEM_ADDR_WIDTH'(3);
    localparam logic [OCC_W-1:0]           DEPTH_OCC  = OCC_W'(FIFO_DEPTH);

    logic [IMEM_ADDR_WIDTH-1:0] pc;
    logic [IMEM_ADDR_WIDTH-1:0] inflight_pc;
    logic                       inflight;
    logic [OCC_W-1:0]           count;
    logic [PTR_W-1:0]           rd_ptr;
    logic [PTR_W-1:0]           wr_ptr;
    logic [IMEM_ADDR_WIDTH-1:0] fifo_pc   [FIFO_DEPTH];
    logic [IMEM_DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];

    logic                       pop;
    logic                       push;
    logic                       issue;
    logic [OCC_W-1:0]           occ_after_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Handshake and issue decisions. The pop term lets issue resume in the
    // same cycle decode frees a slot. pop implies count >= 1, so the
    // subtraction cannot underflow.
    assign inst_valid    = (count != '0);
    assign pop           = inst_valid & inst_ready;
    assign push          = inflight & ~redirect_valid;
    assign occ_after_pop = count + OCC_W'(inflight) - OCC_W'(pop);
    assign issue         = ~rst & ~redirect_valid & (occ_after_pop < DEPTH_OCC);

    assign imem_ena  = issue;
    assign imem_addr = pc;
    assign inst_data = fifo_data[rd_ptr];
    assign inst_pc   = fifo_pc[rd_ptr];

    // Program counter and in-flight tracking; redirect overrides issue.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else if (redirect_valid) begin
            pc       <= redirect_pc & ALIGN_MASK;
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                pc          <= pc + PC_STEP;
                inflight_pc <= pc;
            end
        end
    end

    // FIFO pointers and occupancy; redirect empties the buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else if (redirect_valid) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop)  rd_ptr <= next_ptr(rd_ptr);
            count <= count + OCC_W'(push) - OCC_W'(pop);
        end
    end

    // FIFO storage: captures {inflight_pc, imem_dout} on each accepted response.
    // NOTE: the storage is reset because inst_data/inst_pc are read straight
    // from it and must be zero out of reset; it is only FIFO_DEPTH entries.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_pc[i]   <= '0;
                fifo_data[i] <= '0;
            end
        end else if (push) begin
            fifo_pc[wr_ptr]   <= inflight_pc;
            fifo_data[wr_ptr] <= imem_dout;
        end
    end

    // A push into a full buffer without a matching pop would lose a word.
    no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && (count == DEPTH_OCC)));

endmodule

// File: tb/tb_imem_fetch.sv
// tb_imem_fetch: directed bench for imem_fetch. A table of per-cycle inputs
// and hand-computed outputs drives the main instance (RESET_PC = 0x100);
// hand-written sequences cover reset values, mid-stream reset and PC wrap
// on a second instance (RESET_PC = 0xFFFFFFFC). Memory returns word = address.

module tb_imem_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        imem_ena;
    logic [31:0] imem_addr;
    logic [31:0] imem_dout = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;

    logic        w_ena;
    logic [31:0] w_addr;
    logic [31:0] w_dout = '0;
    logic        w_valid;
    logic [31:0] w_data;
    logic [31:0] w_pc;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    imem_fetch #(.RESET_PC(32'h0000_0100), .FIFO_DEPTH(2)) u_dut (
        .clk            (clk),
        .rst            (rst),
        .imem_ena       (imem_ena),
        .imem_addr      (imem_addr),
        .imem_dout      (imem_dout),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc)
    );

    imem_fetch #(.RESET_PC(32'hFFFF_FFFC), .FIFO_DEPTH(2)) u_wrap (
        .clk            (clk),
        .rst            (rst),
        .imem_ena       (w_ena),
        .imem_addr      (w_addr),
        .imem_dout      (w_dout),
        .redirect_valid (1'b0),
        .redirect_pc    (32'h0),
        .inst_valid     (w_valid),
        .inst_ready     (1'b1),
        .inst_data      (w_data),
        .inst_pc        (w_pc)
    );

    // Synchronous one-cycle-latency memories whose word equals its address.
    always @(posedge clk) begin
        if (imem_ena) imem_dout <= imem_addr;
        if (w_ena)    w_dout    <= w_addr;
    end

    typedef struct {
        logic        ready;
        logic        rv;
        logic [31:0] rpc;
        logic        ena;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] ipc;
    } vec_t;

    vec_t vecs[26];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One table row per cycle: drive after the edge, compare at the negedge.
    task automatic run_vec(input int i);
        inst_ready     = vecs[i].ready;
        redirect_valid = vecs[i].rv;
        redirect_pc    = vecs[i].rpc;
        @(negedge clk);
        check($sformatf("v%0d ena", i),   32'(imem_ena),   32'(vecs[i].ena));
        check($sformatf("v%0d addr", i),  imem_addr,       vecs[i].addr);
        check($sformatf("v%0d valid", i), 32'(inst_valid), 32'(vecs[i].valid));
        if (vecs[i].valid) begin
            check($sformatf("v%0d pc", i),   inst_pc,   vecs[i].ipc);
            check($sformatf("v%0d data", i), inst_data, vecs[i].ipc);
        end
        if (i == 0) begin
            check("wrap ena0",  32'(w_ena), 32'd1);
            check("wrap addr0", w_addr,     32'hFFFF_FFFC);
        end
        if (i == 1) check("wrap addr1", w_addr, 32'h0000_0000);
        if (i == 2) begin
            check("wrap valid2", 32'(w_valid), 32'd1);
            check("wrap pc2",    w_pc,         32'hFFFF_FFFC);
        end
        if (i == 3) check("wrap pc3", w_pc, 32'h0000_0000);
        @(posedge clk);
        #1;
    endtask

    initial begin
        //            ready rv  rpc           ena  addr          valid ipc
        vecs[0]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h100, 1'b0, 32'h0};
        vecs[1]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h104, 1'b0, 32'h0};
        vecs[2]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h108, 1'b1, 32'h100};
        vecs[3]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h10C, 1'b1, 32'h104};
        // Backpressure for five cycles: head held, issue stops once full.
        vecs[4]  = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h110, 1'b1, 32'h108};
        vecs[5]  = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h110, 1'b1, 32'h108};
        vecs[6]  = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h110, 1'b1, 32'h108};
        vecs[7]  = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h110, 1'b1, 32'h108};
        vecs[8]  = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h110, 1'b1, 32'h108};
        // Release: issue resumes in the same cycle, sequence stays contiguous.
        vecs[9]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h110, 1'b1, 32'h108};
        vecs[10] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h114, 1'b1, 32'h10C};
        vecs[11] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h118, 1'b1, 32'h110};
        // Redirect to 0x200 with one buffered and one in flight.
        vecs[12] = '{1'b1, 1'b1, 32'h200, 1'b0, 32'h11C, 1'b1, 32'h114};
        vecs[13] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h200, 1'b0, 32'h0};
        vecs[14] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h204, 1'b0, 32'h0};
        vecs[15] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h208, 1'b1, 32'h200};
        // Misaligned redirect 0x20E fetches from 0x20C.
        vecs[16] = '{1'b1, 1'b1, 32'h20E, 1'b0, 32'h20C, 1'b1, 32'h204};
        vecs[17] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h20C, 1'b0, 32'h0};
        vecs[18] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h210, 1'b0, 32'h0};
        vecs[19] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h214, 1'b1, 32'h20C};
        // Back-to-back redirects: 0x300 then 0x400, only 0x400 delivered.
        vecs[20] = '{1'b1, 1'b1, 32'h300, 1'b0, 32'h218, 1'b1, 32'h210};
        vecs[21] = '{1'b1, 1'b1, 32'h400, 1'b0, 32'h300, 1'b0, 32'h0};
        vecs[22] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h400, 1'b0, 32'h0};
        vecs[23] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h404, 1'b0, 32'h0};
        vecs[24] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h408, 1'b1, 32'h400};
        vecs[25] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h40C, 1'b1, 32'h404};

        // Reset values while rst is held.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst ena",   32'(imem_ena),   32'd0);
        check("rst addr",  imem_addr,       32'h100);
        check("rst valid", 32'(inst_valid), 32'd0);
        check("rst data",  inst_data,       32'h0);
        check("rst pc",    inst_pc,         32'h0);

        // Release reset just after an edge: the next edge is cycle 0.
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 26; i++) run_vec(i);

        // Mid-stream reset: outputs drop at once, response due next is ignored.
        inst_ready     = 1'b1;
        redirect_valid = 1'b0;
        rst            = 1'b1;
        #1;
        check("mid rst ena",   32'(imem_ena),   32'd0);
        check("mid rst valid", 32'(inst_valid), 32'd0);
        check("mid rst addr",  imem_addr,       32'h100);
        check("mid rst data",  inst_data,       32'h0);
        check("mid rst pc",    inst_pc,         32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) run_vec(i);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
